// File: rtl/joypad_poller_pkg.sv
// Shared definitions for the game pad poller.
//   state_e : scan state machine encodings
//   BTN_*   : bit positions of each button in the published snapshot
package joypad_poller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LATCH   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CLK_LO  = 3'd3,
    ST_PUBLISH = 3'd4
  } state_e;

  localparam int unsigned BTN_A      = 0;
  localparam int unsigned BTN_B      = 1;
  localparam int unsigned BTN_SELECT = 2;
  localparam int unsigned BTN_START  = 3;
  localparam int unsigned BTN_UP     = 4;
  localparam int unsigned BTN_DOWN   = 5;
  localparam int unsigned BTN_LEFT   = 6;
  localparam int unsigned BTN_RIGHT  = 7;

endpackage

// File: rtl/joypad_poller_sync2.sv
// Generic two-flop synchroniser for a single asynchronous pin input.
//   clk_i   : destination clock
//   rst_ni  : asynchronous active-low reset; both flops load RST_VAL
//   d_i     : asynchronous input
//   q_o     : synchronised output (2 cycles latency)
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {2{RST_VAL}};
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/joypad_poller.sv
// Scans a 4021-style serial game pad and publishes an active-high button
// snapshot.
//   clk           : system clock
//   rst           : asynchronous active-low reset
//   pad_data      : serial data from the pad (async, low = pressed)
//   poll_now      : request a scan (each high cycle is a request)
//   hold          : defer publishing while high
//   pad_latch     : parallel-load strobe to the pad
//   pad_clk       : shift clock to the pad (idles high)
//   buttons       : last published snapshot, 1 = pressed, bit 0 = A
//   buttons_valid : high in the cycle the snapshot is committed
module joypad_poller
  import joypad_poller_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 300,
  parameter int unsigned POLL_CYCLES = 833333
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pad_data,
  input  logic       poll_now,
  input  logic       hold,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic [7:0] buttons,
  output logic       buttons_valid
);

  localparam int unsigned PH_W  = $clog2(2 * CLK_DIV);
  localparam int unsigned TMR_W = $clog2(POLL_CYCLES);

  localparam logic [PH_W-1:0]  PH_LATCH_LAST = PH_W'(2 * CLK_DIV - 1);
  localparam logic [PH_W-1:0]  PH_HALF_LAST  = PH_W'(CLK_DIV - 1);
  localparam logic [TMR_W-1:0] TMR_LAST      = TMR_W'(POLL_CYCLES - 1);

  state_e           state_q, state_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       buttons_q, buttons_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             pending_q, pending_d;
  logic             timer_tc;
  logic             enter_latch;
  logic             pad_sync;

  sync2 #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk_i  (clk),
    .rst_ni (rst),
    .d_i    (pad_data),
    .q_o    (pad_sync)
  );

  assign timer_tc = (timer_q == TMR_LAST);
  assign timer_d  = timer_tc ? '0 : timer_q + TMR_W'(1);

  // Requests seen while a scan is running stay latched, so any number of
  // them collapse into one follow-up scan.
  assign pending_d = (pending_q & ~enter_latch) | poll_now | timer_tc;

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q + PH_W'(1);
    bit_d         = bit_q;
    shift_d       = shift_q;
    buttons_d     = buttons_q;
    buttons_valid = 1'b0;
    pad_latch     = 1'b0;
    pad_clk       = 1'b1;
    enter_latch   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        phase_d = '0;
        bit_d   = '0;
        if (pending_q) begin
          state_d     = ST_LATCH;
          enter_latch = 1'b1;
        end
      end
      ST_LATCH: begin
        pad_latch = 1'b1;
        if (phase_q == PH_LATCH_LAST) begin
          state_d = ST_WAIT;
          phase_d = '0;
        end
      end
      ST_WAIT: begin
        if (phase_q == PH_HALF_LAST) begin
          shift_d[bit_q] = pad_sync;
          phase_d        = '0;
          state_d        = (bit_q == 3'd7) ? ST_PUBLISH : ST_CLK_LO;
        end
      end
      ST_CLK_LO: begin
        pad_clk = 1'b0;
        if (phase_q == PH_HALF_LAST) begin
          bit_d   = bit_q + 3'd1;
          phase_d = '0;
          state_d = ST_WAIT;
        end
      end
      ST_PUBLISH: begin
        phase_d = '0;
        if (!hold) begin
          buttons_d     = ~shift_q;
          buttons_valid = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      default: begin
        phase_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      phase_q   <= '0;
      bit_q     <= '0;
      shift_q   <= '1;
      buttons_q <= '0;
      timer_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      buttons_q <= buttons_d;
      timer_q   <= timer_d;
      pending_q <= pending_d;
    end
  end

  assign buttons = buttons_q;

endmodule

// File: tb/tb_joypad_poller.sv
module tb_joypad_poller;

  localparam int CLK_DIV     = 4;
  localparam int POLL_CYCLES = 200;

  logic       clk      = 1'b0;
  logic       rst      = 1'b0;
  logic       poll_now = 1'b0;
  logic       hold     = 1'b0;
  logic       pad_data;
  logic       pad_latch;
  logic       pad_clk;
  logic [7:0] buttons;
  logic       buttons_valid;

  // Pad model: parallel load on latch, bit 0 (A) presented first,
  // shifts on the rising edge of pad_clk, ones fill in behind.
  logic [7:0] pad_value = 8'hF6;
  logic [7:0] pad_sr    = 8'hFF;

  always @(posedge pad_latch or posedge pad_clk) begin
    if (pad_latch) pad_sr <= pad_value;
    else           pad_sr <= {1'b1, pad_sr[7:1]};
  end
  assign pad_data = pad_sr[0];

  joypad_poller #(
    .CLK_DIV     (CLK_DIV),
    .POLL_CYCLES (POLL_CYCLES)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pad_data      (pad_data),
    .poll_now      (poll_now),
    .hold          (hold),
    .pad_latch     (pad_latch),
    .pad_clk       (pad_clk),
    .buttons       (buttons),
    .buttons_valid (buttons_valid)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int latch_rises, latch_hi, clk_pulses, bad_pulse, cur_low, valid_cnt, first_valid;
  int rise_cyc [4];
  logic prev_latch, prev_pclk;

  task automatic clear_mon();
    latch_rises = 0; latch_hi = 0; clk_pulses = 0; bad_pulse = 0;
    cur_low = 0; valid_cnt = 0; first_valid = 0;
    for (int i = 0; i < 4; i++) rise_cyc[i] = 0;
    prev_latch = pad_latch;
    prev_pclk  = pad_clk;
  endtask

  // Advance one clock; observe outputs at the falling edge.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (pad_latch && !prev_latch) begin
      if (latch_rises < 4) rise_cyc[latch_rises] = cyc;
      latch_rises++;
    end
    if (pad_latch) latch_hi++;
    if (!pad_clk) begin
      if (prev_pclk) begin clk_pulses++; cur_low = 0; end
      cur_low++;
    end else if (!prev_pclk) begin
      if (cur_low != CLK_DIV) bad_pulse++;
    end
    if (buttons_valid) begin
      valid_cnt++;
      if (first_valid == 0) first_valid = cyc;
    end
    prev_latch = pad_latch;
    prev_pclk  = pad_clk;
  endtask

  task automatic step_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; poll_now = 1'b0; hold = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    cyc = 0;
    clear_mon();
  endtask

  task automatic pulse_poll_at(input int c);
    step_to(c);
    poll_now = 1'b1;
    step();
    poll_now = 1'b0;
  endtask

  task automatic test_reset();
    pad_value = 8'hF6;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (pad_clk !== 1'b1) begin n_fail++; $display("FAIL rst_pad_clk: got %b want 1", pad_clk); end
    n_cmp++; if (pad_latch !== 1'b0) begin n_fail++; $display("FAIL rst_pad_latch: got %b want 0", pad_latch); end
    n_cmp++; if (buttons !== 8'h00) begin n_fail++; $display("FAIL rst_buttons: got %h want 00", buttons); end
    n_cmp++; if (buttons_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", buttons_valid); end
    rst = 1'b1;
    cyc = 0;
    clear_mon();
    step_to(300);
    n_cmp++; if (rise_cyc[0] != 201) begin n_fail++; $display("FAIL timer_first_latch: got %0d want 201", rise_cyc[0]); end
    n_cmp++; if (latch_rises != 1) begin n_fail++; $display("FAIL timer_latch_count: got %0d want 1", latch_rises); end
    n_cmp++; if (latch_hi != 8) begin n_fail++; $display("FAIL timer_latch_len: got %0d want 8", latch_hi); end
    n_cmp++; if (clk_pulses != 7) begin n_fail++; $display("FAIL timer_clk_pulses: got %0d want 7", clk_pulses); end
    n_cmp++; if (bad_pulse != 0) begin n_fail++; $display("FAIL timer_pulse_width: got %0d bad want 0", bad_pulse); end
    n_cmp++; if (first_valid != 269) begin n_fail++; $display("FAIL timer_valid_cyc: got %0d want 269", first_valid); end
    n_cmp++; if (valid_cnt != 1) begin n_fail++; $display("FAIL timer_valid_count: got %0d want 1", valid_cnt); end
    n_cmp++; if (buttons !== 8'h09) begin n_fail++; $display("FAIL timer_buttons: got %h want 09", buttons); end
  endtask

  task automatic test_poll_now();
    do_reset();
    pulse_poll_at(10);
    step_to(150);
    n_cmp++; if (rise_cyc[0] != 12) begin n_fail++; $display("FAIL poll_latch_cyc: got %0d want 12", rise_cyc[0]); end
    n_cmp++; if (latch_rises != 1) begin n_fail++; $display("FAIL poll_latch_count: got %0d want 1", latch_rises); end
    n_cmp++; if (latch_hi != 8) begin n_fail++; $display("FAIL poll_latch_len: got %0d want 8", latch_hi); end
    n_cmp++; if (clk_pulses != 7) begin n_fail++; $display("FAIL poll_clk_pulses: got %0d want 7", clk_pulses); end
    n_cmp++; if (bad_pulse != 0) begin n_fail++; $display("FAIL poll_pulse_width: got %0d bad want 0", bad_pulse); end
    n_cmp++; if (first_valid != 80) begin n_fail++; $display("FAIL poll_valid_cyc: got %0d want 80", first_valid); end
    n_cmp++; if (valid_cnt != 1) begin n_fail++; $display("FAIL poll_valid_count: got %0d want 1", valid_cnt); end
    n_cmp++; if (buttons !== 8'h09) begin n_fail++; $display("FAIL poll_buttons: got %h want 09", buttons); end
  endtask

  task automatic test_back_to_back();
    logic got;
    do_reset();
    step_to(10);
    poll_now = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      step();
      got = buttons_valid;
    end
    poll_now = 1'b0;
    n_cmp++; if (!got) begin n_fail++; $display("FAIL b2b_first_valid: got timeout want pulse"); end
    step_to(260);
    n_cmp++; if (latch_rises != 3) begin n_fail++; $display("FAIL b2b_latch_count: got %0d want 3", latch_rises); end
    n_cmp++; if (rise_cyc[0] != 12) begin n_fail++; $display("FAIL b2b_scan1: got %0d want 12", rise_cyc[0]); end
    n_cmp++; if (rise_cyc[1] != 82) begin n_fail++; $display("FAIL b2b_scan2: got %0d want 82", rise_cyc[1]); end
    n_cmp++; if (rise_cyc[2] != 201) begin n_fail++; $display("FAIL b2b_scan3: got %0d want 201", rise_cyc[2]); end
    n_cmp++; if (first_valid != 80) begin n_fail++; $display("FAIL b2b_valid1: got %0d want 80", first_valid); end
    n_cmp++; if (valid_cnt != 2) begin n_fail++; $display("FAIL b2b_valid_count: got %0d want 2", valid_cnt); end
  endtask

  task automatic test_hold();
    do_reset();
    pulse_poll_at(10);
    step_to(50);
    hold = 1'b1;
    step_to(100);
    n_cmp++; if (valid_cnt != 0) begin n_fail++; $display("FAIL hold_no_valid: got %0d want 0", valid_cnt); end
    n_cmp++; if (buttons !== 8'h00) begin n_fail++; $display("FAIL hold_buttons_kept: got %h want 00", buttons); end
    n_cmp++; if (clk_pulses != 7) begin n_fail++; $display("FAIL hold_scan_ran: got %0d want 7", clk_pulses); end
    n_cmp++; if (latch_rises != 1) begin n_fail++; $display("FAIL hold_no_rescan: got %0d want 1", latch_rises); end
    hold = 1'b0;
    #1;
    n_cmp++; if (buttons_valid !== 1'b1) begin n_fail++; $display("FAIL hold_release_valid: got %b want 1", buttons_valid); end
    n_cmp++; if (buttons !== 8'h00) begin n_fail++; $display("FAIL hold_release_old: got %h want 00", buttons); end
    step();
    n_cmp++; if (buttons !== 8'h09) begin n_fail++; $display("FAIL hold_published: got %h want 09", buttons); end
    n_cmp++; if (buttons_valid !== 1'b0) begin n_fail++; $display("FAIL hold_valid_single: got %b want 0", buttons_valid); end
  endtask

  task automatic test_reset_mid();
    logic got;
    do_reset();
    pulse_poll_at(10);
    step_to(100);
    clear_mon();
    pulse_poll_at(100);
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      step();
      got = (clk_pulses == 4);
    end
    n_cmp++; if (!got) begin n_fail++; $display("FAIL mid_reach_bit3: got timeout want pulse 4"); end
    rst = 1'b0;
    #1;
    n_cmp++; if (pad_clk !== 1'b1) begin n_fail++; $display("FAIL mid_pad_clk: got %b want 1", pad_clk); end
    n_cmp++; if (pad_latch !== 1'b0) begin n_fail++; $display("FAIL mid_pad_latch: got %b want 0", pad_latch); end
    n_cmp++; if (buttons !== 8'h00) begin n_fail++; $display("FAIL mid_buttons: got %h want 00", buttons); end
    n_cmp++; if (buttons_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b want 0", buttons_valid); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    cyc = 0;
    clear_mon();
    pulse_poll_at(10);
    step_to(150);
    n_cmp++; if (clk_pulses != 7) begin n_fail++; $display("FAIL mid_rescan_pulses: got %0d want 7", clk_pulses); end
    n_cmp++; if (first_valid != 80) begin n_fail++; $display("FAIL mid_rescan_valid: got %0d want 80", first_valid); end
    n_cmp++; if (buttons !== 8'h09) begin n_fail++; $display("FAIL mid_rescan_buttons: got %h want 09", buttons); end
  endtask

  task automatic test_release_all();
    do_reset();
    pulse_poll_at(10);
    step_to(90);
    n_cmp++; if (buttons !== 8'h09) begin n_fail++; $display("FAIL ff_before: got %h want 09", buttons); end
    pad_value = 8'hFF;
    clear_mon();
    pulse_poll_at(90);
    step_to(190);
    n_cmp++; if (buttons !== 8'h00) begin n_fail++; $display("FAIL ff_buttons: got %h want 00", buttons); end
    n_cmp++; if (valid_cnt != 1) begin n_fail++; $display("FAIL ff_valid_count: got %0d want 1", valid_cnt); end
    n_cmp++; if (first_valid != 160) begin n_fail++; $display("FAIL ff_valid_cyc: got %0d want 160", first_valid); end
  endtask

  initial begin
    test_reset();
    test_poll_now();
    test_back_to_back();
    test_hold();
    test_reset_mid();
    test_release_all();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
